vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised raster timing generator for the VGA output path. It replaces fixed
//  640x480 sync logic with a generic H/V counter core. Features: runtime pixel-clock
//  enable, selectable sync polarity, registered outputs, line/frame/vblank event
//  pulses and a frame counter. It feeds the pixel renderer (h, v, von) and the
//  object-update logic (frame_start, vblank_start).
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   horizontal sync width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vertical sync width, lines
//  V_BP      33   vertical back porch, lines
//  HS_POL    0    hsync level while asserted (0 = active-low)
//  VS_POL    0    vsync level while asserted
//  CW        11   counter/coordinate width; must satisfy 2^CW >= H_TOTAL and V_TOTAL
//  FRAME_W   8    frame_cnt width
// PORTS
//  clk          in   1        system clock
//  clr          in   1        asynchronous active-high reset
//  pix_en       in   1        pixel strobe; the raster advances only on clk edges where it is 1
//  hsync        out  1        horizontal sync, polarity HS_POL
//  vsync        out  1        vertical sync, polarity VS_POL
//  von          out  1        1 while the current pixel is in the visible area
//  h            out  CW       visible x, 0..H_ACTIVE-1; 0 outside the visible area
//  v            out  CW       visible y, 0..V_ACTIVE-1; 0 in vertical blanking
//  line_start   out  1        1-clk pulse at hc==0 of every line
//  frame_start  out  1        1-clk pulse at hc==0, vc==0
//  vblank_start out  1        1-clk pulse at hc==0, vc==V_ACTIVE (object refresh window)
//  frame_cnt    out  FRAME_W  number of frame_start pulses, wraps modulo 2^FRAME_W
// BEHAVIOUR
//  - Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//  - Line order: active, FP, sync, BP. hc=0 is the first visible pixel.
//  - Internal counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1).
//  - On a clk edge with pix_en=1:
//      hc wraps to 0 at H_TOTAL-1, else hc+1.
//      vc advances only when hc wraps, and wraps to 0 at V_TOTAL-1.
//  - Outputs are registered decodes of the pre-increment (hc,vc) at that same edge,
//    so they lag the counters by one pix_en:
//      von    = hc<H_ACTIVE && vc<V_ACTIVE
//      h      = hc when von else 0
//      v      = vc when vc<V_ACTIVE else 0
//      hsync  = HS_POL while H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL
//      vsync  = VS_POL while V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (whole lines), else ~VS_POL
//  - Edges with pix_en=0: counters, von, h, v, hsync and vsync hold.
//  - line_start, frame_start and vblank_start are forced to 0 on the next clk edge
//    regardless of pix_en, so each pulse is exactly one clk wide.
//  - frame_cnt increments in the same edge that raises frame_start.
//    The first frame after reset reads 1.
//  - Reset (async, immediate):
//      hc=vc=0, h=v=0, von=0, all pulses 0, frame_cnt=0,
//      hsync=~HS_POL, vsync=~VS_POL.
//    Reset mid-frame abandons the frame. The first pix_en after clr falls
//    produces von=1, h=0, v=0, line_start=frame_start=1.
//  - pix_en asserted continuously gives one pixel per clk.
// TESTING
//  T1 defaults, pix_en=1, release clr -> edge 1: von=1,h=0,v=0,frame_start=1,frame_cnt=1; hsync low exactly when hc 656..751 (96 clks).
//  T2 defaults, one full frame -> 420000 pix_en between frame_starts; 307200 von cycles; max h=639, max v=479.
//  T3 defaults -> vsync low for lines 490..491 only (1600 pix_en); vblank_start once at line 480, hc=0.
//  T4 pix_en every 2nd clk -> frame length 840000 clk; all pulses still exactly 1 clk wide; outputs hold on pix_en=0 edges.
//  T5 clr mid-frame at hc=300,vc=200 -> all outputs at reset values before next edge; restart at (0,0) with frame_start.
//  T6 H 8/2/2/2, V 4/1/1/1, HS_POL=VS_POL=1, FRAME_W=2 -> 14x7 raster, positive syncs, frame_cnt 1,2,3,0 over 4 frames.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised H/V raster timing core with registered decodes,
// pixel-clock enable, selectable sync polarity, event pulses and a frame counter.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int CW       = 11,
   parameter int FRAME_W  = 8
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               pix_en,
   output logic               hsync,
   output logic               vsync,
   output logic               von,
   output logic [CW-1:0]      h,
   output logic [CW-1:0]      v,
   output logic               line_start,
   output logic               frame_start,
   output logic               vblank_start,
   output logic [FRAME_W-1:0] frame_cnt
);
   localparam logic [CW-1:0] HA  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] HS0 = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS1 = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] HL  = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CW-1:0] VA  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] VS0 = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS1 = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] VL  = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic HP = 1'(HS_POL);
   localparam logic VP = 1'(VS_POL);

   logic [CW-1:0] hc, vc;
   logic hw, vis_h, vis_v, top;

   always_comb begin
      hw    = hc == HL;
      vis_h = hc < HA;
      vis_v = vc < VA;
      top   = hc == '0;
   end

   // pulses self-clear every clk; everything else advances only on pix_en
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         hc           <= '0;
         vc           <= '0;
         h            <= '0;
         v            <= '0;
         von          <= 1'b0;
         hsync        <= ~HP;
         vsync        <= ~VP;
         line_start   <= 1'b0;
         frame_start  <= 1'b0;
         vblank_start <= 1'b0;
         frame_cnt    <= '0;
      end else begin
         line_start   <= 1'b0;
         frame_start  <= 1'b0;
         vblank_start <= 1'b0;
         if (pix_en) begin
            hc           <= hw ? '0 : hc + 1'b1;
            if (hw) vc   <= vc == VL ? '0 : vc + 1'b1;
            von          <= vis_h && vis_v;
            h            <= vis_h && vis_v ? hc : '0;
            v            <= vis_v ? vc : '0;
            hsync        <= hc >= HS0 && hc < HS1 ? HP : ~HP;
            vsync        <= vc >= VS0 && vc < VS1 ? VP : ~VP;
            line_start   <= top;
            frame_start  <= top && vc == '0;
            vblank_start <= top && vc == VA;
            if (top && vc == '0) frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks a default 640x480 instance and a tiny 14x7 positive-sync
// instance against a position-arithmetic raster model, plus literal spot values.
module tb_vga_timing_gen;
   logic clk = 1'b0;
   logic clr_a = 1'b1, clr_b = 1'b1, en_a = 1'b0, en_b = 1'b0;
   logic hs_a, vs_a, von_a, ls_a, fs_a, vb_a;
   logic [10:0] h_a, v_a;
   logic [7:0] cnt_a;
   logic hs_b, vs_b, von_b, ls_b, fs_b, vb_b;
   logic [3:0] h_b, v_b;
   logic [1:0] cnt_b;
   int total = 0, bad = 0;
   int na = 0, nb = 0;
   bit ea = 1'b0, eb = 1'b0;

   always #5 clk = ~clk;

   vga_timing_gen dut_a (
      .clk(clk), .clr(clr_a), .pix_en(en_a), .hsync(hs_a), .vsync(vs_a), .von(von_a),
      .h(h_a), .v(v_a), .line_start(ls_a), .frame_start(fs_a), .vblank_start(vb_a),
      .frame_cnt(cnt_a));

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
      .V_BP(1), .HS_POL(1), .VS_POL(1), .CW(4), .FRAME_W(2)
   ) dut_b (
      .clk(clk), .clr(clr_b), .pix_en(en_b), .hsync(hs_b), .vsync(vs_b), .von(von_b),
      .h(h_b), .v(v_b), .line_start(ls_b), .frame_start(fs_b), .vblank_start(vb_b),
      .frame_cnt(cnt_b));

   task automatic chk(string nm, longint act, longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // expected outputs after n pixel steps since reset; e = last edge had pix_en
   function automatic logic [47:0] model(int n, bit e, int ha, int hfp, int hsw, int hbp,
                                          int va, int vfp, int vsw, int vbp, bit hp, bit vp,
                                          int fw);
      int ht = ha + hfp + hsw + hbp;
      int vt = va + vfp + vsw + vbp;
      int pos, x, y, c;
      bit vis, hs, vs;
      if (n == 0) return {1'b0, ~hp, ~vp, 3'b000, 2'b00, 8'd0, 16'd0, 16'd0};
      pos = (n - 1) % (ht * vt);
      x = pos % ht;
      y = pos / ht;
      vis = x < ha && y < va;
      hs = (x >= ha + hfp && x < ha + hfp + hsw) ? hp : ~hp;
      vs = (y >= va + vfp && y < va + vfp + vsw) ? vp : ~vp;
      c = ((n - 1) / (ht * vt) + 1) % (1 << fw);
      return {vis, hs, vs, e && x == 0, e && pos == 0, e && x == 0 && y == va, 2'b00,
              8'(c), 16'(vis ? x : 0), 16'(y < va ? y : 0)};
   endfunction

   always @(posedge clk or posedge clr_a)
      if (clr_a) begin na <= 0; ea <= 1'b0; end
      else begin ea <= en_a; if (en_a) na <= na + 1; end

   always @(posedge clk or posedge clr_b)
      if (clr_b) begin nb <= 0; eb <= 1'b0; end
      else begin eb <= en_b; if (en_b) nb <= nb + 1; end

   always @(negedge clk) begin
      if (!clr_a)
         chk("raster_a", {von_a, hs_a, vs_a, ls_a, fs_a, vb_a, 2'b00, cnt_a, 16'(h_a), 16'(v_a)},
             model(na, ea, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 8));
      if (!clr_b)
         chk("raster_b", {von_b, hs_b, vs_b, ls_b, fs_b, vb_b, 2'b00, 8'(cnt_b), 16'(h_b), 16'(v_b)},
             model(nb, eb, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 2));
   end

   initial begin
      int low_cnt = 0, first_low = 0, cyc = 0, nfs = 0, fs_cyc = 0;
      int von_cnt = 0, vs_cnt = 0, vb_cnt = 0;
      repeat (3) @(negedge clk);
      chk("rst_a", {von_a, hs_a, vs_a, ls_a, fs_a, vb_a, cnt_a, h_a, v_a}, 35'h600000000);
      chk("rst_b", {hs_b, vs_b, von_b, cnt_b, h_b}, 0);
      // T1: first edge and hsync window on the default raster
      #1 en_a = 1'b1; clr_a = 1'b0;
      for (int i = 1; i <= 800; i++) begin
         @(negedge clk);
         if (i == 1) begin
            chk("t1_von", von_a, 1);
            chk("t1_fs", fs_a, 1);
            chk("t1_cnt", cnt_a, 1);
            chk("t1_hv", {h_a, v_a}, 0);
         end
         if (!hs_a) begin low_cnt++; if (first_low == 0) first_low = i; end
      end
      chk("t1_hs_first", first_low, 657);
      chk("t1_hs_len", low_cnt, 96);
      // T5: reset mid-line at hc=300 of line 1
      repeat (301) @(negedge clk);
      chk("t5_pos", {von_a, h_a, v_a}, {1'b1, 11'd300, 11'd1});
      #1 clr_a = 1'b1;
      #1 chk("t5_rst", {von_a, hs_a, vs_a, ls_a, fs_a, cnt_a, h_a, v_a}, 34'h300000000);
      @(negedge clk);
      #1 clr_a = 1'b0;
      @(negedge clk);
      chk("t5_restart", {von_a, fs_a, ls_a, cnt_a, h_a, v_a}, {3'b111, 8'd1, 22'd0});
      repeat (50) @(negedge clk);
      #1 en_a = 1'b0;
      // T4/T6: tiny raster, pix_en every second clk
      clr_b = 1'b0;
      en_b = 1'b1;
      for (int i = 1; i <= 830; i++) begin
         @(negedge clk);
         cyc++;
         if (fs_b) begin
            nfs++;
            if (nfs == 1) chk("t6_cnt1", cnt_b, 1);
            if (nfs == 2) chk("t6_cnt2", cnt_b, 2);
            if (nfs == 3) chk("t6_cnt3", cnt_b, 3);
            if (nfs == 4) chk("t6_cnt4", cnt_b, 0);
            if (nfs == 2) chk("t4_frame_clks", cyc - fs_cyc, 196);
            fs_cyc = cyc;
         end
         if (nfs == 1) begin
            von_cnt += von_b;
            vs_cnt += vs_b;
            vb_cnt += vb_b;
         end
         #1 en_b = ~en_b;
      end
      chk("t4_nframes", nfs, 5);
      chk("t6_von", von_cnt, 64);
      chk("t6_vsync", vs_cnt, 28);
      chk("t6_vblank", vb_cnt, 1);
      en_b = 1'b1;
      repeat (20) @(negedge clk);
      #1 clr_b = 1'b1;
      #1 chk("t5_rst_b", {hs_b, vs_b, von_b, ls_b, fs_b, vb_b, cnt_b, h_b, v_b}, 0);
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
